i2c_master: RTL

Single-master I2C controller that performs one complete single-byte transaction per request: START, 7-bit address + R/W, ACK check, one data byte written or read, STOP. It is the controller end of the bus served by the `i2c` target block (default target address 7'h69). It drives open-drain SCL/SDA through release-high outputs and supports target clock stretching.

---
 rtl/i2c_pkg.sv | 41 ++++
 rtl/i2c_quarter_tick.sv | 40 ++++
 rtl/i2c_master.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C controller and target blocks:
//   - state_t     : controller FSM state encoding
//   - Q0..Q3      : quarter indices inside a bit slot
//   - TARGET_ADDR_DEFAULT : default 7-bit address of the i2c target block
//   - is_slot / is_byte : classify states that run 4-quarter bit slots
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WACK,
    S_READ,
    S_RNACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [6:0] TARGET_ADDR_DEFAULT = 7'h69;

  // States built from 4-quarter bit slots (data bytes and ACK bits).
  function automatic logic is_slot(state_t s);
    return s inside {S_ADDR, S_ADDR_ACK, S_WRITE, S_WACK, S_READ, S_RNACK};
  endfunction

  // States that carry 8 bit slots rather than a single one.
  function automatic logic is_byte(state_t s);
    return s inside {S_ADDR, S_WRITE, S_READ};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// -----------------------------------------------------------------------------
// i2c_quarter_tick
// Divides clk into SCL quarter periods of CLK_DIV cycles.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-low reset
//   i_clr    in  hold the counter at 0 (controller idle)
//   i_freeze in  hold the counter on its last count (SCL stretch)
//   o_tick   out high on the last cycle of each quarter
// -----------------------------------------------------------------------------
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_freeze,
  output logic o_tick
);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == 8'(CLK_DIV - 1));
  // A frozen quarter simply stays on its last count until released.
  assign o_tick = w_last && !i_freeze;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else if (!w_last) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
// Single-master I2C controller: START, address+R/W, ACK, one data byte
// (write or read), STOP, one transaction per start_i request.
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   start_i             transaction request (accepted in IDLE only)
//   rw_i/addr_i/wdata_i 1=read / 7-bit target address / write byte
//   busy_o              transaction in progress
//   done_o              one-cycle pulse at transaction end
//   ack_err_o           target NACKed; held until the next start
//   rdata_o             read byte, loaded at done_o of a good read
//   scl_o/sda_o         open-drain drive: 0 = pull low, 1 = release
//   scl_i/sda_i         bus levels, registered once before use
// -----------------------------------------------------------------------------
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic [7:0] rdata_o,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  state_t     r_state, w_state_nxt, w_state_after;
  logic [1:0] r_q, w_q_nxt, w_q_last;
  logic [2:0] r_bit, w_bit_nxt;

  logic       r_rw;
  logic [6:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic [7:0] r_rdata;
  logic       r_ack_err;
  logic       r_scl_in, r_sda_in;
  logic       r_sample;
  logic       r_scl_o, r_sda_o;
  logic       r_busy, r_done;

  logic       w_tick, w_clr, w_freeze;

  // Bus pin levels for a given position in the transaction: {scl, sda}.
  function automatic logic [1:0] bus_drive(state_t s, logic [1:0] q, logic [2:0] b,
                                           logic [7:0] addr_byte, logic [7:0] data_byte);
    unique case (s)
      S_START:                             bus_drive = 2'b10;
      S_ADDR:                              bus_drive = {q[1], addr_byte[3'd7 - b]};
      S_WRITE:                             bus_drive = {q[1], data_byte[3'd7 - b]};
      S_ADDR_ACK, S_WACK, S_READ, S_RNACK: bus_drive = {q[1], 1'b1};
      S_STOP:                              bus_drive = {q != Q0, q == Q2};
      default:                             bus_drive = 2'b11;
    endcase
  endfunction

  assign w_clr    = (r_state == S_IDLE) || (r_state == S_DONE);
  // Hold Q2 while a target stretches SCL; only the last count is affected.
  assign w_freeze = is_slot(r_state) && (r_q == Q2) && !r_scl_in;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_freeze (w_freeze),
    .o_tick   (w_tick)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_q_nxt       = r_q;
    w_bit_nxt     = r_bit;
    w_q_last      = Q3;
    w_state_after = S_IDLE;

    unique case (r_state)
      S_START:    begin w_q_last = Q1; w_state_after = S_ADDR;     end
      S_ADDR:     w_state_after = S_ADDR_ACK;
      // r_ack_err was updated on Q3's first cycle, before this slot ends.
      S_ADDR_ACK: w_state_after = r_ack_err ? S_STOP : (r_rw ? S_READ : S_WRITE);
      S_WRITE:    w_state_after = S_WACK;
      S_WACK:     w_state_after = S_STOP;
      S_READ:     w_state_after = S_RNACK;
      S_RNACK:    w_state_after = S_STOP;
      S_STOP:     begin w_q_last = Q2; w_state_after = S_DONE;     end
      default:    ;
    endcase

    unique case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_START;
      S_DONE: w_state_nxt = S_IDLE;
      default: begin
        if (w_tick) begin
          if (r_q == w_q_last) begin
            w_q_nxt = Q0;
            if (is_byte(r_state) && (r_bit != 3'd7)) begin
              w_bit_nxt = r_bit + 3'd1;
            end else begin
              w_bit_nxt   = 3'd0;
              w_state_nxt = w_state_after;
            end
          end else begin
            w_q_nxt = r_q + 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_q       <= Q0;
      r_bit     <= 3'd0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_rdata   <= '0;
      r_ack_err <= 1'b0;
      r_scl_in  <= 1'b1;
      r_sda_in  <= 1'b1;
      r_sample  <= 1'b0;
      r_scl_o   <= 1'b1;
      r_sda_o   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_bit    <= w_bit_nxt;
      r_scl_in <= scl_i;
      r_sda_in <= sda_i;

      // Pins are decoded from the next position so they line up with r_state.
      {r_scl_o, r_sda_o} <= bus_drive(w_state_nxt, w_q_nxt, w_bit_nxt,
                                      {r_addr, r_rw}, r_wdata);
      r_busy <= !(w_state_nxt inside {S_IDLE, S_DONE});
      r_done <= (w_state_nxt == S_DONE);

      // Flags the first cycle of Q3, when the registered SDA is sampled.
      r_sample <= w_tick && (r_q == Q2) && is_slot(r_state);

      if ((r_state == S_IDLE) && start_i) begin
        r_rw      <= rw_i;
        r_addr    <= addr_i;
        r_wdata   <= wdata_i;
        r_ack_err <= 1'b0;
      end

      if (r_sample) begin
        unique case (r_state)
          S_ADDR_ACK, S_WACK: if (r_sda_in) r_ack_err <= 1'b1;
          S_READ:             r_shift <= {r_shift[6:0], r_sda_in};
          default:            ;
        endcase
      end

      if ((r_state == S_STOP) && (w_state_nxt == S_DONE) && r_rw && !r_ack_err) begin
        r_rdata <= r_shift;
      end
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign ack_err_o = r_ack_err;
  assign rdata_o   = r_rdata;
  assign scl_o     = r_scl_o;
  assign sda_o     = r_sda_o;

endmodule
